// File: rtl/cache_fill_if.sv
// cache_fill_if: miss/memory/array signal bundle between a cache and its fill controller
// master: fill controller (takes miss + memory return, drives requests and array writes)
// slave: cache/memory side (drives miss + memory return, takes requests and array writes)
interface cache_fill_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int IDX = $clog2(WORDS_PER_BLOCK);
  localparam int OFF = IDX + 1;
  logic                      miss_detected;
  logic [ADDR_WIDTH-1:0]     miss_address;
  logic                      memory_data_valid;
  logic [15:0]               memory_data;
  logic                      fsm_busy;
  logic                      mem_en;
  logic [ADDR_WIDTH-1:0]     memory_address;
  logic                      write_data_array;
  logic [IDX-1:0]            data_array_word;
  logic [15:0]               data_array_wdata;
  logic                      write_tag_array;
  logic [ADDR_WIDTH-OFF-1:0] fill_tag;
  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_en, memory_address, write_data_array, data_array_word,
           data_array_wdata, write_tag_array, fill_tag
  );
  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_en, memory_address, write_data_array, data_array_word,
           data_array_wdata, write_tag_array, fill_tag
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler issuing one block of word reads and steering returns into the cache arrays
// clk, rst: clock, synchronous active-high reset
// bus (master): miss_detected/miss_address in, memory_data_valid/memory_data in,
//   fsm_busy, mem_en/memory_address, write_data_array/data_array_word/data_array_wdata,
//   write_tag_array/fill_tag out
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.master bus
);
  localparam int IDX = $clog2(WORDS_PER_BLOCK);
  localparam int OFF = IDX + 1;
  localparam logic [IDX:0]   NW   = (IDX+1)'(WORDS_PER_BLOCK);
  localparam logic [IDX-1:0] LAST = IDX'(WORDS_PER_BLOCK - 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t                    state_q;
  logic [IDX:0]              iss_q;
  logic [IDX-1:0]            rcv_q;
  logic [ADDR_WIDTH-OFF-1:0] tag_q;
  logic                      fill, issue, wr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iss_q   <= '0;
      rcv_q   <= '0;
      tag_q   <= '0;
    end else if (state_q == IDLE) begin
      if (bus.miss_detected) begin
        tag_q   <= bus.miss_address[ADDR_WIDTH-1:OFF];
        iss_q   <= '0;
        rcv_q   <= '0;
        state_q <= FILL;
      end
    end else begin
      if (iss_q < NW) iss_q <= iss_q + 1'b1;
      if (bus.memory_data_valid) begin
        rcv_q <= rcv_q + 1'b1;
        if (rcv_q == LAST) state_q <= IDLE;
      end
    end
  end
  // Outputs are forced low during reset so a mid-fill rst never leaks a write.
  assign fill  = !rst && state_q == FILL;
  assign issue = fill && iss_q < NW;
  assign wr    = fill && bus.memory_data_valid;
  assign bus.fsm_busy         = fill;
  assign bus.mem_en           = issue;
  // Offset is spliced in rather than added, so the top block cannot carry out of its offset field.
  assign bus.memory_address   = issue ? {tag_q, iss_q[IDX-1:0], 1'b0} : '0;
  assign bus.write_data_array = wr;
  assign bus.data_array_word  = wr ? rcv_q : '0;
  assign bus.data_array_wdata = wr ? bus.memory_data : '0;
  assign bus.write_tag_array  = wr && rcv_q == LAST;
  assign bus.fill_tag         = fill ? tag_q : '0;
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the cache arrays and the 16-bit word-wide backing memory.
- On a miss, captures the block address and issues WORDS_PER_BLOCK consecutive word reads to a pipelined multi-cycle memory.
- Steers each returned word into the cache data array, then writes the tag array once the block is complete.
- The CPU stalls on fsm_busy. One instance serves I-cache, one serves D-cache.

Parameters:
- ADDR_WIDTH, 16, byte address width; bit 0 of every word address is 0.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, >= 2.
- Derived, not a parameter: OFF = log2(WORDS_PER_BLOCK)+1 byte-offset bits (4 at default); IDX = log2(WORDS_PER_BLOCK).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  ADDR_WIDTH  byte address of the missing access
- memory_data_valid  in  1  memory returns a word this cycle
- memory_data  in  16  returned word
- fsm_busy  out  1  fill in progress; CPU stalls
- mem_en  out  1  read request to memory this cycle
- memory_address  out  ADDR_WIDTH  word address of the current request
- write_data_array  out  1  write data_array_wdata into the block at data_array_word
- data_array_word  out  IDX  word index within the block being written
- data_array_wdata  out  16  equals memory_data
- write_tag_array  out  1  one-cycle pulse: install fill_tag
- fill_tag  out  ADDR_WIDTH-OFF  tag of the block being filled

Behaviour:
- States: IDLE, FILL. State, base address, issue count (iss) and receive count (rcv) are registered. All other outputs are combinational from state, counters and inputs.
- Reset: state=IDLE, iss=0, rcv=0, base=0. While rst is high and in the cycle after, every output is 0.
- IDLE:
  - miss_detected=1 at a clock edge: base <= {miss_address[ADDR_WIDTH-1:OFF], OFF zeros}; iss <= 0; rcv <= 0; go to FILL.
  - memory_data_valid is ignored; no array writes.
- FILL:
  - fsm_busy=1.
  - Issue: mem_en=1 while iss < WORDS_PER_BLOCK. memory_address = base + 2*iss. iss increments each cycle until it reaches WORDS_PER_BLOCK, then mem_en=0. Words are issued on WORDS_PER_BLOCK consecutive cycles starting in the first FILL cycle.
  - Receive: memory_data_valid=1 gives write_data_array=1, data_array_word=rcv, data_array_wdata=memory_data, and rcv increments. Valid may arrive in the same cycle as an issue; issue and receive are independent.
  - Completion: when valid=1 and rcv=WORDS_PER_BLOCK-1, write_data_array=1 and write_tag_array=1 in the same cycle; next state is IDLE.
  - fill_tag = base[ADDR_WIDTH-1:OFF], stable for the whole fill.
  - miss_detected and miss_address are ignored; the base is not re-captured.
- Valid pulses beyond WORDS_PER_BLOCK cannot occur because FILL exits on the last one. Valid in IDLE is dropped.
- A new miss is accepted in the first IDLE cycle after completion. The back-to-back miss latency is one IDLE cycle.
- rst mid-fill: immediate return to IDLE, counters cleared, no tag write. Partially written data words remain but are unreachable because the tag was never written.
- Latency: the FSM does not depend on memory latency. With a 4-cycle memory (address in cycle c, data in c+4) and a miss sampled at edge 0:
  - issues occur in cycles 1-8;
  - writes occur in cycles 5-12;
  - write_tag_array fires in cycle 12;
  - fsm_busy is 1 in cycles 1-12.
- Address arithmetic is ADDR_WIDTH bits; a block at the top of the address space never carries past its own offset field.

Test Plan:
- Reset, then idle 5 cycles with memory_data_valid toggling -> all outputs 0 throughout, no array writes.
- Miss at miss_address=0x1236, 4-cycle memory -> memory_address 0x1230,0x1232,…,0x123E in cycles 1-8; write_data_array in cycles 5-12 with data_array_word 0..7; write_tag_array only in cycle 12 with fill_tag=0x123; fsm_busy low in cycle 13.
- Same fill with a memory inserting random 1-3 cycle gaps between valid pulses -> exactly 8 data writes in order 0..7, a single tag pulse on the 8th write, fsm_busy held until then.
- Second miss (0xFFF8) held asserted throughout the fill of 0x0040 -> the 0x0040 block completes unaffected; FSM re-enters FILL one cycle after completion with base 0xFFF0 and addresses 0xFFF0-0xFFFE, no wrap into 0x0000.
- rst asserted in cycle 6 of a fill -> next cycle all outputs 0, no write_tag_array; a fresh miss afterwards completes a normal 8-word fill.
- memory_data_valid=1 in the same cycle as the miss edge, and in IDLE after completion -> no write_data_array, rcv unaffected.
